sisc_ir_sequencer: RTL and testbench
====================================

Name: sisc_ir_sequencer

Overview:
Synthesizable instruction-stream player that drives the SISC `ir` input from a loadable program table, replacing hard-coded timed stimulus. Instructions are written into an internal table, then issued one at a time, each held for a programmable number of clocks. Playback stops on a halt opcode, at end of program, or on abort; it can optionally loop. It sits between the bench or host loader and the `sisc` core.

Parameters:
IR_WIDTH, 32, instruction word width
DEPTH, 16, program table entries (power of 2, ≥2)
HOLD_CYCLES, 5, clocks each instruction is held on ir (≥1)
HALT_OPC, 4'hF, opcode in ir[IR_WIDTH-1 -: 4] that terminates playback
CNT_WIDTH, 16, width of issued-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_f  in  1  synchronous active-low reset, sampled on rising clk
load_en  in  1  write load_data into table[load_addr] (IDLE/DONE only)
load_addr  in  clog2(DEPTH)  table write address
load_data  in  IR_WIDTH  table write data
prog_len  in  clog2(DEPTH)+1  number of valid entries, sampled at start
start  in  1  begin playback from entry 0
loop_en  in  1  wrap to entry 0 after last entry instead of finishing (sampled at start)
abort  in  1  stop playback immediately
ir  out  IR_WIDTH  instruction presented to core
ir_valid  out  1  ir holds a live issued instruction
pc  out  clog2(DEPTH)  table index of current ir
busy  out  1  state==RUN
done  out  1  playback finished; held until next start or reset
halted  out  1  with done: finish caused by HALT_OPC
issue_cnt  out  CNT_WIDTH  instructions issued since start, saturating

Behaviour:
- Reset (rst_f=0 at clk edge): state=IDLE; ir=0 (NOP); ir_valid=0; pc=0; busy=0; done=0; halted=0; issue_cnt=0; hold counter=0. Table contents are not reset. Reset mid-RUN behaves identically, with no partial advance.
- States: IDLE, RUN, DONE.
- Table write: at a clk edge with load_en=1 and state≠RUN, table[load_addr]=load_data. load_en is ignored in RUN.
- Start (IDLE or DONE, start=1, load_en=0, prog_len≠0): at that edge, state=RUN; pc=0; ir=table[0]; ir_valid=1; hold=0; issue_cnt=1; done=halted=0; len and loop_en latched.
  - start is ignored when prog_len=0, when load_en=1 in the same cycle (the load wins), or in RUN.
- RUN: hold increments each clock.
  - When hold==HOLD_CYCLES-1 at an edge, the current word is complete and the next edge's action is decided by the current word:
  - Opcode==HALT_OPC: go to DONE; done=1; halted=1. Halt takes priority over loop.
  - Else if pc==len-1 and loop=1: pc=0; ir=table[0]; hold=0; issue_cnt+1.
  - Else if pc==len-1 and loop=0: go to DONE; done=1; halted=0.
  - Else: pc+1; ir=table[pc+1]; hold=0; issue_cnt+1.
- Each word therefore occupies ir for exactly HOLD_CYCLES clocks. First word appears 1 clock after start is sampled; no bubble between words.
- Entering DONE: ir retains the last word; ir_valid=0; busy=0; pc retains its value.
- Abort in RUN (abort=1 at edge): go to DONE the same edge; ir=0; ir_valid=0; done=1; halted=0. abort takes priority over any advance, and is ignored outside RUN.
- issue_cnt saturates at all-ones and holds.
- prog_len > DEPTH is clamped to DEPTH.
- Table read is combinational (or uses the registered-next-address form) so that ir updates on the advance edge.

Test Plan:
1. Reset then defaults: hold rst_f=0 for 2 clocks -> ir=0, ir_valid=0, busy=0, done=0, issue_cnt=0; the table is unchanged afterwards.
2. Load {8802000A, 88030007, 80231002, F0000000}, prog_len=4, start (HOLD_CYCLES=5) -> ir steps through the four words on edges start+1, +6, +11, +16. At edge +21: done=1, halted=1, issue_cnt=4, ir=F0000000.
3. Load {8802000A, 88030007}, prog_len=2, loop_en=1, start, run 25 clocks -> ir sequence A,B,A,B,A with 5 clocks each; pc toggles 0/1; issue_cnt=5; done stays 0.
4. Same program with loop_en=0 -> done=1 and halted=0 at edge start+11; a new start restarts from pc=0 with issue_cnt=1.
5. Abort on the 3rd clock of word 1 -> next edge: ir=0, ir_valid=0, done=1, halted=0. A load_en pulse during RUN leaves the table unchanged (confirmed by readback replay).
6. Simultaneous start+load_en in IDLE -> the write lands and start is ignored (busy stays 0). start with prog_len=0 -> no change. rst_f=0 mid-RUN -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/sisc_ir_sequencer_if.sv
// rtl/sisc_ir_sequencer_if.sv - loader/control and instruction-output bundle for the SISC ir sequencer
//
// Purpose: groups the host loader, playback control and core-facing outputs.
// master modport: host/bench side (drives load/control, observes outputs).
// slave modport : sequencer side (observes load/control, drives outputs).
//   load_en, load_addr, load_data : program table write port
//   prog_len, start, loop_en, abort : playback control
//   ir, ir_valid, pc               : instruction stream to the core
//   busy, done, halted, issue_cnt  : playback status
interface sisc_ir_sequencer_if #(
    parameter int IR_WIDTH  = 32,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                 load_en;
    logic [AW-1:0]        load_addr;
    logic [IR_WIDTH-1:0]  load_data;
    logic [AW:0]          prog_len;
    logic                 start;
    logic                 loop_en;
    logic                 abort;
    logic [IR_WIDTH-1:0]  ir;
    logic                 ir_valid;
    logic [AW-1:0]        pc;
    logic                 busy;
    logic                 done;
    logic                 halted;
    logic [CNT_WIDTH-1:0] issue_cnt;

    modport master (
        output load_en, load_addr, load_data, prog_len, start, loop_en, abort,
        input  ir, ir_valid, pc, busy, done, halted, issue_cnt
    );

    modport slave (
        input  load_en, load_addr, load_data, prog_len, start, loop_en, abort,
        output ir, ir_valid, pc, busy, done, halted, issue_cnt
    );
endinterface

// File: rtl/sisc_ir_sequencer.sv
// rtl/sisc_ir_sequencer.sv - loadable instruction-table player driving the SISC core ir input
//
// Purpose: instructions are written into an internal table while idle, then
// issued one at a time, each held on ir for HOLD_CYCLES clocks. Playback ends
// on a HALT_OPC word, at the end of the program (unless looping) or on abort.
// Ports:
//   clk   : system clock, rising edge
//   rst_f : synchronous active-low reset
//   bus   : sisc_ir_sequencer_if.slave (loader, control, ir stream, status)
module sisc_ir_sequencer #(
    parameter int          IR_WIDTH    = 32,
    parameter int          DEPTH       = 16,
    parameter int          HOLD_CYCLES = 5,
    parameter logic [3:0]  HALT_OPC    = 4'hF,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_f,
    sisc_ir_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [IR_WIDTH-1:0]  ir_q, ir_d;
    logic                 valid_q, valid_d;
    logic [AW-1:0]        pc_q, pc_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 halted_q, halted_d;
    logic [LW-1:0]        len_q, len_d;
    logic                 loop_q, loop_d;

    logic [IR_WIDTH-1:0]  mem [DEPTH];

    logic                 hold_last;
    logic                 last_entry;
    logic                 is_halt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [AW-1:0]        pc_next;
    logic [LW-1:0]        len_clamped;

    // Table storage is deliberately not reset; only the write port is gated by state.
    always_ff @(posedge clk) begin
        if (bus.load_en && state_q != RUN) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign hold_last   = (hold_q == HW'(HOLD_CYCLES - 1));
    assign last_entry  = ({1'b0, pc_q} == (len_q - LW'(1)));
    assign is_halt     = (ir_q[IR_WIDTH-1 -: 4] == HALT_OPC);
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign pc_next     = pc_q + AW'(1);
    assign len_clamped = (bus.prog_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.prog_len;

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        pc_d     = pc_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        halted_d = halted_q;
        len_d    = len_q;
        loop_d   = loop_q;

        unique case (state_q)
            IDLE, DONE: begin
                // A simultaneous load wins over start so the host never races its own write.
                if (bus.start && !bus.load_en && bus.prog_len != '0) begin
                    state_d  = RUN;
                    pc_d     = '0;
                    ir_d     = mem[0];
                    valid_d  = 1'b1;
                    hold_d   = '0;
                    cnt_d    = CNT_WIDTH'(1);
                    done_d   = 1'b0;
                    halted_d = 1'b0;
                    len_d    = len_clamped;
                    loop_d   = bus.loop_en;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d  = DONE;
                    ir_d     = '0;
                    valid_d  = 1'b0;
                    done_d   = 1'b1;
                    halted_d = 1'b0;
                end else if (hold_last) begin
                    // The word just completed decides what happens next; halt beats loop.
                    if (is_halt) begin
                        state_d  = DONE;
                        valid_d  = 1'b0;
                        done_d   = 1'b1;
                        halted_d = 1'b1;
                    end else if (last_entry && loop_q) begin
                        pc_d   = '0;
                        ir_d   = mem[0];
                        hold_d = '0;
                        cnt_d  = cnt_inc;
                    end else if (last_entry) begin
                        state_d  = DONE;
                        valid_d  = 1'b0;
                        done_d   = 1'b1;
                        halted_d = 1'b0;
                    end else begin
                        pc_d   = pc_next;
                        ir_d   = mem[pc_next];
                        hold_d = '0;
                        cnt_d  = cnt_inc;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q  <= IDLE;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
            len_q    <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            halted_q <= halted_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
        end
    end

    assign bus.ir        = ir_q;
    assign bus.ir_valid  = valid_q;
    assign bus.pc        = pc_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.halted    = halted_q;
    assign bus.issue_cnt = cnt_q;
endmodule

// File: tb/tb_sisc_ir_sequencer.sv
// tb/tb_sisc_ir_sequencer.sv - self-checking bench for sisc_ir_sequencer
module tb_sisc_ir_sequencer;
    localparam int IR_WIDTH = 32;
    localparam int DEPTH    = 16;
    localparam int HOLD     = 5;
    localparam int CNTW     = 16;

    localparam logic [31:0] W_A = 32'h8802000A;
    localparam logic [31:0] W_B = 32'h88030007;
    localparam logic [31:0] W_C = 32'h80231002;
    localparam logic [31:0] W_H = 32'hF0000000;
    localparam logic [31:0] W_X = 32'h12345678;

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_f = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sisc_ir_sequencer_if #(.IR_WIDTH(IR_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) bus ();

    sisc_ir_sequencer #(
        .IR_WIDTH(IR_WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD),
        .HALT_OPC(4'hF), .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk),
        .rst_f(rst_f),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every clock that ir_valid is high must match the next expected word.
    always @(negedge clk) begin
        if (rst_f && bus.ir_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(bus.ir), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ir_stream", 64'(bus.ir), 64'(e.ir));
                check("pc_stream", 64'(bus.pc), 64'(e.pc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic [3:0] p, input int n);
        exp_t e;
        e.ir = w;
        e.pc = p;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        step();
        bus.load_en   = 1'b0;
    endtask

    task automatic start_prog(input logic [4:0] len, input logic lp);
        bus.prog_len = len;
        bus.loop_en  = lp;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            step();
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic check_status(input string tag, input logic dn, input logic hl,
                                input logic [15:0] cnt, input logic [31:0] w, input logic v);
        check({tag, "_done"},   64'(bus.done),      64'(dn));
        check({tag, "_halted"}, 64'(bus.halted),    64'(hl));
        check({tag, "_cnt"},    64'(bus.issue_cnt), 64'(cnt));
        check({tag, "_ir"},     64'(bus.ir),        64'(w));
        check({tag, "_valid"},  64'(bus.ir_valid),  64'(v));
    endtask

    initial begin
        bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
        bus.prog_len = 0; bus.start = 0; bus.loop_en = 0; bus.abort = 0;

        // reset defaults
        rst_f = 0; step(); step();
        check_status("rst", 0, 0, 0, 32'h0, 0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_pc",   64'(bus.pc),   64'd0);
        rst_f = 1; step();

        // load halt program, reset again; playback proves the table survived reset
        load(0, W_A); load(1, W_B); load(2, W_C); load(3, W_H);
        rst_f = 0; step(); step(); rst_f = 1; step();
        push(W_A, 0, HOLD); push(W_B, 1, HOLD); push(W_C, 2, HOLD); push(W_H, 3, HOLD);
        start_prog(4, 0);
        check("run_busy", 64'(bus.busy), 64'd1);
        wait_drain();
        step();
        check_status("halt", 1, 1, 4, W_H, 0);
        check("halt_busy", 64'(bus.busy), 64'd0);
        check("halt_pc",   64'(bus.pc),   64'd3);

        // two-word loop, 25 clocks
        load(0, W_A); load(1, W_B);
        push(W_A, 0, HOLD); push(W_B, 1, HOLD); push(W_A, 0, HOLD);
        push(W_B, 1, HOLD); push(W_A, 0, HOLD);
        start_prog(2, 1);
        wait_drain();
        check("loop_cnt",  64'(bus.issue_cnt), 64'd5);
        check("loop_done", 64'(bus.done),      64'd0);
        check("loop_busy", 64'(bus.busy),      64'd1);
        bus.abort = 1; step(); bus.abort = 0;
        check_status("loop_abort", 1, 0, 5, 32'h0, 0);

        // same program, no loop, then restart
        push(W_A, 0, HOLD); push(W_B, 1, HOLD);
        start_prog(2, 0);
        wait_drain();
        step();
        check_status("end", 1, 0, 2, W_B, 0);
        push(W_A, 0, HOLD); push(W_B, 1, HOLD);
        start_prog(2, 0);
        check("restart_cnt", 64'(bus.issue_cnt), 64'd1);
        check("restart_done", 64'(bus.done), 64'd0);
        wait_drain();
        step();
        check_status("end2", 1, 0, 2, W_B, 0);

        // abort on 3rd clock of word 1, with an ignored load during RUN
        load(2, W_C);
        push(W_A, 0, HOLD); push(W_B, 1, 3);
        start_prog(3, 0);
        bus.load_en = 1; bus.load_addr = 1; bus.load_data = 32'hDEADBEEF;
        step();
        bus.load_en = 0;
        wait_drain();
        bus.abort = 1; step(); bus.abort = 0;
        check_status("abort", 1, 0, 2, 32'h0, 0);
        push(W_A, 0, HOLD); push(W_B, 1, HOLD); push(W_C, 2, HOLD);
        start_prog(3, 0);
        wait_drain();
        step();
        check_status("replay", 1, 0, 3, W_C, 0);

        // start+load in IDLE: load wins
        rst_f = 0; step(); rst_f = 1; step();
        bus.load_en = 1; bus.load_addr = 0; bus.load_data = W_X;
        bus.prog_len = 1; bus.loop_en = 0; bus.start = 1;
        step();
        bus.load_en = 0; bus.start = 0;
        check("startload_busy",  64'(bus.busy),     64'd0);
        check("startload_valid", 64'(bus.ir_valid), 64'd0);
        // start with prog_len=0 ignored
        start_prog(0, 0);
        check("len0_busy", 64'(bus.busy), 64'd0);
        check("len0_done", 64'(bus.done), 64'd0);
        push(W_X, 0, HOLD);
        start_prog(1, 0);
        wait_drain();
        step();
        check_status("single", 1, 0, 1, W_X, 0);

        // reset mid-RUN
        push(W_X, 0, 3);
        start_prog(1, 1);
        wait_drain();
        rst_f = 0; step();
        check_status("midrst", 0, 0, 0, 32'h0, 0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_pc",   64'(bus.pc),   64'd0);
        rst_f = 1; step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
